tpu_sequencer: RTL and testbench
================================

Name: tpu_sequencer

Overview:
Parametrised successor to the single-opcode TPU control unit. It decodes a 16-bit instruction stream under a valid/ready handshake and expands each multi-cycle opcode into a timed burst of control strobes with auto-incrementing addresses. Targets: the systolic array (weight load, input load, compute) and the unified buffer (store). Sits between the instruction source and the array/buffer datapath; all outputs are registered.

Parameters:
INSTR_W, 16, instruction width
OPC_W, 3, opcode field width (instr[INSTR_W-1 -: OPC_W])
ADDR_W, 13, address width (instr[ADDR_W-1:0] for LOAD_ADDR); INSTR_W = OPC_W + ADDR_W
ARRAY_N, 2, systolic array dimension (rows per weight/input/store burst)
CNT_W, 8, RUN vector-count field width (instr[CNT_W-1:0])

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr  in  INSTR_W  instruction word
instr_valid  in  1  instr is valid this cycle
instr_ready  out  1  sequencer can accept an instruction
base_address  out  ADDR_W  latched base address
load_weight  out  1  weight-row load strobe
load_input  out  1  input-row load strobe
compute_en  out  1  array compute enable
store_en  out  1  result store strobe
row_addr  out  ADDR_W  base_address + row index during load/store bursts, else 0
row_idx  out  $clog2(ARRAY_N)  current row within a burst, else 0
busy  out  1  state != IDLE
halted  out  1  sticky, set by HALT
illegal  out  1  sticky, set by an undefined opcode

Behaviour:
- Reset (synchronous, any state, including mid-burst): state=IDLE; all strobes, row_addr, row_idx, base_address=0; halted=0, illegal=0; instr_ready=1 on the first cycle after reset is released.
- Accept: rising edge with instr_valid && instr_ready. instr_ready = (state==IDLE) && !halted. When instr_ready=0, instr is ignored.
- States: IDLE, LOAD_W, LOAD_I, RUN, STORE, HALT.
- 000 LOAD_ADDR: base_address <= instr[ADDR_W-1:0] at the accept edge. Remains in IDLE, so back-to-back accepts are possible every cycle.
- 001 LOAD_WEIGHT: IDLE->LOAD_W. For ARRAY_N cycles starting the cycle after accept, load_weight=1 and row_idx=0..ARRAY_N-1.
- 010 LOAD_INPUT: same timing in LOAD_I with load_input.
- 100 STORE: same timing in STORE with store_en.
- All bursts: row_addr = (base_address + row_idx) mod 2^ADDR_W, so the address wraps at the top.
- 011 RUN: K = instr[CNT_W-1:0].
  - K=0: no-op, stays IDLE.
  - K>0: compute_en=1 for exactly K + 2*ARRAY_N - 2 cycles (fill/drain). The cycle counter is CNT_W+$clog2(2*ARRAY_N)+1 bits, so it cannot overflow.
- Burst end: the last strobe cycle returns to IDLE at its closing edge, so instr_ready=1 on the following cycle. Total occupancy per burst is burst length + 0 idle cycles; the next accept is possible on the first ready cycle.
- 111 HALT: halted<=1, state HALT, instr_ready=0 until reset.
- 101/110: illegal<=1 (sticky), treated as a NOP, stays IDLE.
- At most one strobe is high in any cycle.
- base_address changes only via LOAD_ADDR or reset. It is never altered mid-burst.

Decomposition:
- Package tpu_pkg:
  - opcode localparams OP_LOAD_ADDR=3'b000, OP_LOAD_WEIGHT=3'b001, OP_LOAD_INPUT=3'b010, OP_RUN=3'b011, OP_STORE=3'b100, OP_HALT=3'b111
  - state enum
  - field-slice helper constants
- One sub-module, tpu_burst_counter: loadable down-counter with a done flag and up-running row index. It is shared by all burst states.

Test Plan:
- Reset then LOAD_ADDR 0x0040 -> base_address=0x0040 next cycle, instr_ready stays 1, busy=0.
- LOAD_ADDR 0x0040, LOAD_WEIGHT (ARRAY_N=2) -> load_weight high 2 cycles, row_addr 0x0040,0x0041, row_idx 0,1; instr_ready low exactly those 2 cycles.
- LOAD_ADDR 0x1FFF, STORE -> row_addr 0x1FFF then 0x0000 (wrap); store_en 2 cycles.
- RUN K=3 (ARRAY_N=2) -> compute_en high exactly 5 consecutive cycles. RUN K=0 -> no strobe, instr_ready never drops.
- Opcode 101 -> illegal=1 and sticky, no strobe. HALT -> halted=1, instr_ready=0; a following valid LOAD_WEIGHT is ignored.
- Assert reset during the 2nd RUN cycle -> next cycle all strobes 0, state IDLE, base_address=0, instr_ready=1 after release.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared opcodes, sequencer state encoding and field-width helpers for the
// TPU instruction sequencer.
package tpu_pkg;

    localparam int OPC_FIELD_W = 3;

    localparam logic [OPC_FIELD_W-1:0] OP_LOAD_ADDR   = 3'b000;
    localparam logic [OPC_FIELD_W-1:0] OP_LOAD_WEIGHT = 3'b001;
    localparam logic [OPC_FIELD_W-1:0] OP_LOAD_INPUT  = 3'b010;
    localparam logic [OPC_FIELD_W-1:0] OP_RUN         = 3'b011;
    localparam logic [OPC_FIELD_W-1:0] OP_STORE       = 3'b100;
    localparam logic [OPC_FIELD_W-1:0] OP_HALT        = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_I,
        S_RUN,
        S_STORE,
        S_HALT
    } state_e;

    // A 1-row array still needs a 1-bit row index to keep ports legal.
    function automatic int ridx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wide enough for K + 2*ARRAY_N - 2 with no overflow.
    function automatic int run_cnt_w(input int cnt_w, input int n);
        return cnt_w + $clog2(2 * n) + 1;
    endfunction

endpackage

// File: rtl/tpu_sequencer_if.sv
// Instruction handshake and array/buffer control bundle of the TPU sequencer.
interface tpu_sequencer_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 13,
    parameter int ARRAY_N = 2
);
    localparam int RIDX_W = tpu_pkg::ridx_w(ARRAY_N);

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  base_address;
    logic               load_weight;
    logic               load_input;
    logic               compute_en;
    logic               store_en;
    logic [ADDR_W-1:0]  row_addr;
    logic [RIDX_W-1:0]  row_idx;
    logic               busy;
    logic               halted;
    logic               illegal;

    modport master (
        output instr, instr_valid,
        input  instr_ready, base_address, load_weight, load_input, compute_en,
               store_en, row_addr, row_idx, busy, halted, illegal
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, base_address, load_weight, load_input, compute_en,
               store_en, row_addr, row_idx, busy, halted, illegal
    );

endinterface

// File: rtl/tpu_burst_counter.sv
// Loadable down-counter timing one burst; row index counts up alongside it
// only for row-addressed bursts (load/store), staying 0 for RUN.
module tpu_burst_counter #(
    parameter int CW     = 11,
    parameter int RIDX_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              track_i,
    input  logic [CW-1:0]     len_i,
    output logic              done_o,
    output logic [RIDX_W-1:0] row_idx_o
);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RIDX_W-1:0] row_q, row_d;
    logic              track_q, track_d;

    always_comb begin
        cnt_d   = cnt_q;
        row_d   = row_q;
        track_d = track_q;
        if (load_i) begin
            cnt_d   = len_i;
            row_d   = '0;
            track_d = track_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                row_d   = '0;
                track_d = 1'b0;
            end else if (track_q) begin
                row_d = row_q + RIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            row_q   <= '0;
            track_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            track_q <= track_d;
        end
    end

    assign done_o    = (cnt_q == CW'(1));
    assign row_idx_o = row_q;

endmodule

// File: rtl/tpu_sequencer.sv
// Decodes the instruction stream and expands each opcode into a timed burst
// of registered control strobes for the systolic array and unified buffer.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 3,
    parameter int ADDR_W  = 13,
    parameter int ARRAY_N = 2,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    tpu_sequencer_if.slave  bus
);
    localparam int RIDX_W = ridx_w(ARRAY_N);
    localparam int CW     = run_cnt_w(CNT_W, ARRAY_N);
    localparam logic [CW-1:0] BURST_LEN  = CW'(ARRAY_N);
    localparam logic [CW-1:0] FILL_DRAIN = CW'(2 * ARRAY_N - 2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic              lw_q, li_q, ce_q, st_q;

    logic                   accept;
    logic [OPC_FIELD_W-1:0] opc;
    logic [CNT_W-1:0]       run_k;
    logic                   cnt_load, cnt_track, cnt_done;
    logic [CW-1:0]          cnt_len;
    logic [RIDX_W-1:0]      row_idx;
    logic                   row_burst;

    assign opc       = bus.instr[INSTR_W-1 -: OPC_W];
    assign run_k     = bus.instr[CNT_W-1:0];
    assign accept    = bus.instr_valid && bus.instr_ready;
    assign row_burst = (state_q == S_LOAD_W) || (state_q == S_LOAD_I) || (state_q == S_STORE);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        cnt_load  = 1'b0;
        cnt_track = 1'b0;
        cnt_len   = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opc)
                        OP_LOAD_ADDR: base_d = bus.instr[ADDR_W-1:0];
                        OP_LOAD_WEIGHT, OP_LOAD_INPUT, OP_STORE: begin
                            state_d   = (opc == OP_LOAD_WEIGHT) ? S_LOAD_W :
                                        (opc == OP_LOAD_INPUT)  ? S_LOAD_I : S_STORE;
                            cnt_load  = 1'b1;
                            cnt_track = 1'b1;
                            cnt_len   = BURST_LEN;
                        end
                        OP_RUN: begin
                            if (run_k != '0) begin
                                state_d  = S_RUN;
                                cnt_load = 1'b1;
                                cnt_len  = CW'(run_k) + FILL_DRAIN;
                            end
                        end
                        OP_HALT: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_LOAD_W, S_LOAD_I, S_RUN, S_STORE: begin
                if (cnt_done) state_d = S_IDLE;
            end
            default: ;
        endcase

        // Row address is registered alongside the strobes: seeded from the base
        // on a load/store accept, then stepped once per row until the burst ends.
        row_addr_d = '0;
        if (cnt_load && cnt_track) begin
            row_addr_d = base_q;
        end else if (row_burst && !cnt_done) begin
            row_addr_d = row_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            row_addr_q <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            lw_q       <= 1'b0;
            li_q       <= 1'b0;
            ce_q       <= 1'b0;
            st_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            row_addr_q <= row_addr_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            lw_q       <= (state_d == S_LOAD_W);
            li_q       <= (state_d == S_LOAD_I);
            ce_q       <= (state_d == S_RUN);
            st_q       <= (state_d == S_STORE);
        end
    end

    tpu_burst_counter #(
        .CW     (CW),
        .RIDX_W (RIDX_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cnt_load),
        .track_i   (cnt_track),
        .len_i     (cnt_len),
        .done_o    (cnt_done),
        .row_idx_o (row_idx)
    );

    assign bus.instr_ready  = (state_q == S_IDLE) && !halted_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.base_address = base_q;
    assign bus.load_weight  = lw_q;
    assign bus.load_input   = li_q;
    assign bus.compute_en   = ce_q;
    assign bus.store_en     = st_q;
    assign bus.row_addr     = row_addr_q;
    assign bus.row_idx      = row_idx;
    assign bus.halted       = halted_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: directed instructions push expected
// strobe cycles; a negedge monitor pops and compares every strobe cycle.
module tb_tpu_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tpu_sequencer_if #(.INSTR_W(16), .ADDR_W(13), .ARRAY_N(2)) bus ();

    tpu_sequencer #(
        .INSTR_W (16),
        .OPC_W   (3),
        .ADDR_W  (13),
        .ARRAY_N (2),
        .CNT_W   (8)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // kind = {load_weight, load_input, compute_en, store_en}
    typedef struct {
        logic [3:0]  kind;
        logic [12:0] addr;
        logic [0:0]  idx;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    localparam logic [3:0] K_W = 4'b1000;
    localparam logic [3:0] K_I = 4'b0100;
    localparam logic [3:0] K_C = 4'b0010;
    localparam logic [3:0] K_S = 4'b0001;

    logic [3:0] strobes;
    assign strobes = {bus.load_weight, bus.load_input, bus.compute_en, bus.store_en};

    always @(negedge clk) begin
        if (strobes != 4'b0000) begin
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_strobe: cyc=%0d strobes=%b row_addr=%h expected none",
                         cyc, strobes, bus.row_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (strobes !== e.kind || bus.row_addr !== e.addr ||
                    bus.row_idx !== e.idx || cyc != e.cyc) begin
                    nerr++;
                    $display("FAIL strobe_cycle: got kind=%b addr=%h idx=%0d cyc=%0d, expected kind=%b addr=%h idx=%0d cyc=%0d",
                             strobes, bus.row_addr, bus.row_idx, cyc, e.kind, e.addr, e.idx, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] w, output int a);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        a = cyc;
    endtask

    task automatic push_burst(input logic [3:0] kind, input logic [12:0] base,
                              input int len, input int a);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.kind = kind;
            e.addr = (kind == K_C) ? 13'h0000 : base + 13'(i);
            e.idx  = (kind == K_C) ? 1'b0 : 1'(i);
            e.cyc  = a + i;
            sb.push_back(e);
        end
    endtask

    // Called in the first strobe cycle; ready must be low for len cycles, then high.
    task automatic watch_ready(input string nm, input int len);
        for (int i = 0; i <= len; i++) begin
            chk(nm, {31'b0, bus.instr_ready}, {31'b0, (i == len)});
            if (i < len) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int a;
        rst             = 1'b1;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_base",    32'(bus.base_address), 32'h0);
        chk("rst_strobes", 32'(strobes), 32'h0);
        chk("rst_busy",    32'(bus.busy), 32'h0);
        chk("rst_halted",  32'(bus.halted), 32'h0);
        chk("rst_illegal", 32'(bus.illegal), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.instr_ready), 32'h1);

        issue(16'h0040, a);
        chk("la_base",  32'(bus.base_address), 32'h0040);
        chk("la_ready", 32'(bus.instr_ready), 32'h1);
        chk("la_busy",  32'(bus.busy), 32'h0);

        issue(16'h2000, a);
        push_burst(K_W, 13'h0040, 2, a);
        chk("lw_busy", 32'(bus.busy), 32'h1);
        watch_ready("lw_ready", 2);

        issue(16'h1FFF, a);
        chk("la2_base", 32'(bus.base_address), 32'h1FFF);
        issue(16'h8000, a);
        push_burst(K_S, 13'h1FFF, 2, a);
        watch_ready("st_ready", 2);

        issue(16'h0100, a);
        issue(16'h4000, a);
        push_burst(K_I, 13'h0100, 2, a);
        watch_ready("li_ready", 2);

        issue(16'h6003, a);
        push_burst(K_C, 13'h0000, 5, a);
        watch_ready("run3_ready", 5);
        chk("run3_base_kept", 32'(bus.base_address), 32'h0100);

        issue(16'h6000, a);
        for (int i = 0; i < 3; i++) begin
            chk("run0_ready", 32'(bus.instr_ready), 32'h1);
            chk("run0_busy",  32'(bus.busy), 32'h0);
            @(posedge clk);
            #1;
        end

        issue(16'hA000, a);
        chk("op101_illegal", 32'(bus.illegal), 32'h1);
        chk("op101_ready",   32'(bus.instr_ready), 32'h1);
        issue(16'h0005, a);
        chk("illegal_sticky", 32'(bus.illegal), 32'h1);
        chk("la3_base",       32'(bus.base_address), 32'h0005);
        issue(16'hC000, a);
        chk("op110_busy", 32'(bus.busy), 32'h0);

        // Reset during the second RUN cycle: strobes must clear the cycle after.
        issue(16'h0077, a);
        issue(16'h6003, a);
        push_burst(K_C, 13'h0000, 2, a);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_strobes", 32'(strobes), 32'h0);
        chk("mid_rst_busy",    32'(bus.busy), 32'h0);
        chk("mid_rst_base",    32'(bus.base_address), 32'h0);
        chk("mid_rst_illegal", 32'(bus.illegal), 32'h0);
        chk("mid_rst_raddr",   32'(bus.row_addr), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 32'(bus.instr_ready), 32'h1);

        issue(16'h0033, a);
        issue(16'hE000, a);
        chk("halt_halted", 32'(bus.halted), 32'h1);
        chk("halt_ready",  32'(bus.instr_ready), 32'h0);
        chk("halt_busy",   32'(bus.busy), 32'h1);
        bus.instr       = 16'h2000;
        bus.instr_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.instr_valid = 1'b0;
        chk("halt_sticky", 32'(bus.halted), 32'h1);
        chk("halt_ready2", 32'(bus.instr_ready), 32'h0);
        chk("halt_base",   32'(bus.base_address), 32'h0033);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected summary");
        $fatal(1);
    end

endmodule
